// File: rtl/car_drive_controller_if.sv
// ---------------------------------------------------------------------------
// car_drive_controller_if
// Purpose : bundles the board-side buttons/switches and the status outputs of
//           the car drive controller so they travel as one port.
// Signals :
//   power_btn, mode_btn, left_btn, right_btn : raw push buttons, active-high
//   clutch, throttle, brake, reverse         : slide switches (1 = engaged)
//   power_state  : 1 = powered on
//   driving_mode : 00 manual, 01 semi-auto, 10 auto
//   car_state    : 00 NOT_STARTING, 01 STARTING, 10 MOVING
//   turn_show    : [1] left indicator, [0] right indicator
//   mileage      : completed mileage ticks, binary
// Modports: master = board/stimulus side, slave = controller side.
// ---------------------------------------------------------------------------
interface car_drive_controller_if;
  logic        power_btn;
  logic        mode_btn;
  logic        left_btn;
  logic        right_btn;
  logic        clutch;
  logic        throttle;
  logic        brake;
  logic        reverse;
  logic        power_state;
  logic [1:0]  driving_mode;
  logic [1:0]  car_state;
  logic [1:0]  turn_show;
  logic [15:0] mileage;

  modport master (
    output power_btn, mode_btn, left_btn, right_btn,
    output clutch, throttle, brake, reverse,
    input  power_state, driving_mode, car_state, turn_show, mileage
  );

  modport slave (
    input  power_btn, mode_btn, left_btn, right_btn,
    input  clutch, throttle, brake, reverse,
    output power_state, driving_mode, car_state, turn_show, mileage
  );
endinterface

// File: rtl/car_drive_controller.sv
// ---------------------------------------------------------------------------
// car_drive_controller
// Purpose : central sequencing FSM of the car demo. Debounces the four push
//           buttons, sequences power / driving mode / manual car state from
//           the clutch, throttle, brake and reverse switches, drives the turn
//           indicators and accumulates mileage while moving.
// Ports   :
//   sys_clk : 100 MHz system clock, all state updates on its rising edge
//   rst     : synchronous active-high reset
//   bus     : car_drive_controller_if.slave (buttons/switches in, status out)
// Params  :
//   DEBOUNCE_CYCLES : stable raw samples needed before a button level is taken
//   MILE_TICK       : MOVING cycles per mileage increment
// ---------------------------------------------------------------------------
module car_drive_controller #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int MILE_TICK       = 100_000_000
) (
  input logic                   sys_clk,
  input logic                   rst,
  car_drive_controller_if.slave bus
);

  typedef enum logic [1:0] {
    NOT_STARTING = 2'b00,
    STARTING     = 2'b01,
    MOVING       = 2'b10
  } car_state_e;

  typedef enum logic [1:0] {
    MANUAL    = 2'b00,
    SEMI_AUTO = 2'b01,
    AUTO      = 2'b10
  } drive_mode_e;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int PS_W = (MILE_TICK > 1) ? $clog2(MILE_TICK) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(MILE_TICK - 1);

  // Button index order: 3 power, 2 mode, 1 left, 0 right.
  logic [3:0]      raw;
  logic [3:0]      level_q;
  logic [3:0]      press_q;
  logic [DB_W-1:0] cnt_q [4];

  logic            power_q;
  drive_mode_e     mode_q;
  car_state_e      car_q;
  logic [1:0]      turn_q;
  logic            rev_q;
  logic [PS_W-1:0] presc_q;
  logic            tick_q;
  logic [15:0]     mileage_q;

  logic rev_edge;
  logic stall;

  assign raw = {bus.power_btn, bus.mode_btn, bus.left_btn, bus.right_btn};

  // Debounce: a counter per button runs while the raw level differs from the
  // accepted level and restarts whenever they agree. The accepted level only
  // flips after DEBOUNCE_CYCLES consecutive differing samples, and the press
  // pulse fires on exactly that cycle for a 0->1 flip, so a held button
  // yields a single pulse.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        press_q[i] <= 1'b0;
        if (raw[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          cnt_q[i]   <= '0;
          level_q[i] <= raw[i];
          press_q[i] <= raw[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // A reverse toggle is seen against last cycle's sampled level.
  assign rev_edge = bus.reverse ^ rev_q;

  // Conditions that kill the engine in manual mode: throttle without clutch
  // from standstill, or a gear reversal without clutch while moving.
  assign stall = (mode_q == MANUAL) && !bus.clutch &&
                 (((car_q == NOT_STARTING) && bus.throttle) ||
                  ((car_q == MOVING) && rev_edge));

  // Main sequencer. Power press beats everything; a stall pre-empts mode and
  // turn updates in the same cycle. Car state is only evaluated in manual
  // mode and is pinned to NOT_STARTING in the automatic modes.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      power_q <= 1'b0;
      mode_q  <= MANUAL;
      car_q   <= NOT_STARTING;
      turn_q  <= 2'b00;
      rev_q   <= 1'b0;
    end else begin
      rev_q <= bus.reverse;
      if (press_q[3]) begin
        power_q <= ~power_q;
        car_q   <= NOT_STARTING;
        turn_q  <= 2'b00;
      end else if (power_q) begin
        if (stall) begin
          power_q <= 1'b0;
          car_q   <= NOT_STARTING;
          turn_q  <= 2'b00;
        end else begin
          if (press_q[2] && (car_q == NOT_STARTING)) begin
            case (mode_q)
              MANUAL:    mode_q <= SEMI_AUTO;
              SEMI_AUTO: mode_q <= AUTO;
              default:   mode_q <= MANUAL;
            endcase
          end

          if (press_q[1] && press_q[0]) begin
            turn_q <= 2'b00;
          end else if (press_q[1]) begin
            turn_q <= turn_q[1] ? 2'b00 : 2'b10;
          end else if (press_q[0]) begin
            turn_q <= turn_q[0] ? 2'b00 : 2'b01;
          end

          if (mode_q != MANUAL) begin
            car_q <= NOT_STARTING;
          end else begin
            case (car_q)
              NOT_STARTING: begin
                if (bus.throttle && bus.clutch && !bus.brake) car_q <= STARTING;
              end
              STARTING: begin
                if (bus.brake)                         car_q <= NOT_STARTING;
                else if (bus.throttle && !bus.clutch)  car_q <= MOVING;
              end
              MOVING: begin
                if (bus.brake)                         car_q <= NOT_STARTING;
                else if (bus.clutch || !bus.throttle)  car_q <= STARTING;
              end
              default: car_q <= NOT_STARTING;
            endcase
          end
        end
      end
    end
  end

  // Mileage: the prescaler only advances while MOVING and keeps its partial
  // count otherwise; the odometer bumps the cycle after the prescaler wraps.
  // Power-off does not clear the odometer, only rst does.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      mileage_q <= '0;
    end else begin
      tick_q <= 1'b0;
      if (car_q == MOVING) begin
        if (presc_q == PS_LAST) begin
          presc_q <= '0;
          tick_q  <= 1'b1;
        end else begin
          presc_q <= presc_q + PS_W'(1);
        end
      end
      if (tick_q) mileage_q <= mileage_q + 16'd1;
    end
  end

  assign bus.power_state  = power_q;
  assign bus.driving_mode = mode_q;
  assign bus.car_state    = car_q;
  assign bus.turn_show    = turn_q;
  assign bus.mileage      = mileage_q;

endmodule

// File: tb/tb_car_drive_controller.sv
// ---------------------------------------------------------------------------
// tb_car_drive_controller
// Purpose : self-checking bench for car_drive_controller. A table of
//           {inputs, hold cycles, expected outputs} records drives the main
//           scenarios; hand-written sequences cover reset while moving, power
//           press against a simultaneous stall, and odometer wrap (on a second
//           instance with a one-cycle mileage tick).
// Expected outputs are packed as {power, mode[1:0], car[1:0], turn[1:0],
// mileage[15:0]} and pass through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_car_drive_controller;

  localparam int DB = 4;
  localparam int MT = 10;

  // Stimulus bit masks: {power, mode, left, right, clutch, throttle, brake, reverse}
  localparam logic [7:0] P  = 8'h80;
  localparam logic [7:0] MD = 8'h40;
  localparam logic [7:0] L  = 8'h20;
  localparam logic [7:0] R  = 8'h10;
  localparam logic [7:0] C  = 8'h08;
  localparam logic [7:0] T  = 8'h04;
  localparam logic [7:0] B  = 8'h02;
  localparam logic [7:0] V  = 8'h01;

  typedef struct {
    string       name;
    logic [7:0]  stim;
    int          cycles;
    logic [22:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [22:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];
  sb_t  sbq[$];

  car_drive_controller_if ifc ();
  car_drive_controller_if ifc2 ();

  car_drive_controller #(.DEBOUNCE_CYCLES(DB), .MILE_TICK(MT)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (ifc)
  );

  car_drive_controller #(.DEBOUNCE_CYCLES(DB), .MILE_TICK(1)) dut2 (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (ifc2)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] pk(input logic p, input logic [1:0] m,
                                     input logic [1:0] c, input logic [1:0] t,
                                     input logic [15:0] mi);
    return {p, m, c, t, mi};
  endfunction

  function automatic logic [22:0] dutOut();
    return {ifc.power_state, ifc.driving_mode, ifc.car_state, ifc.turn_show, ifc.mileage};
  endfunction

  function automatic logic [22:0] dut2Out();
    return {ifc2.power_state, ifc2.driving_mode, ifc2.car_state, ifc2.turn_show, ifc2.mileage};
  endfunction

  task automatic setInputs(input logic [7:0] s);
    ifc.power_btn = s[7];
    ifc.mode_btn  = s[6];
    ifc.left_btn  = s[5];
    ifc.right_btn = s[4];
    ifc.clutch    = s[3];
    ifc.throttle  = s[2];
    ifc.brake     = s[1];
    ifc.reverse   = s[0];
  endtask

  task automatic setInputs2(input logic [7:0] s);
    ifc2.power_btn = s[7];
    ifc2.mode_btn  = s[6];
    ifc2.left_btn  = s[5];
    ifc2.right_btn = s[4];
    ifc2.clutch    = s[3];
    ifc2.throttle  = s[2];
    ifc2.brake     = s[1];
    ifc2.reverse   = s[0];
  endtask

  task automatic addVec(input string n, input logic [7:0] s, input int cyc,
                        input logic p, input logic [1:0] m, input logic [1:0] c,
                        input logic [1:0] t, input logic [15:0] mi);
    vec_t v;
    v.name   = n;
    v.stim   = s;
    v.cycles = cyc;
    v.exp    = pk(p, m, c, t, mi);
    vecs.push_back(v);
  endtask

  // Drive a record, queue its expectation, then let it act for its cycles.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    setInputs(v.stim);
    e.name = v.name;
    e.exp  = v.exp;
    sbq.push_back(e);
    repeat (v.cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input logic [22:0] act);
    sb_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: actual=%h with no expected entry", act);
      return;
    end
    e = sbq.pop_front();
    if (act !== e.exp) begin
      failures++;
      $display("[TB] FAIL %s: actual pwr=%b mode=%b car=%b turn=%b mile=%h, expected pwr=%b mode=%b car=%b turn=%b mile=%h",
               e.name, act[22], act[21:20], act[19:18], act[17:16], act[15:0],
               e.exp[22], e.exp[21:20], e.exp[19:18], e.exp[17:16], e.exp[15:0]);
    end
  endtask

  task automatic step(input string n, input logic [7:0] s, input int cyc,
                      input logic p, input logic [1:0] m, input logic [1:0] c,
                      input logic [1:0] t, input logic [15:0] mi);
    vec_t v;
    v.name   = n;
    v.stim   = s;
    v.cycles = cyc;
    v.exp    = pk(p, m, c, t, mi);
    applyStimulus(v);
    checkOutput(dutOut());
  endtask

  task automatic step2(input string n, input logic [7:0] s, input int cyc,
                       input logic [22:0] ex);
    sb_t e;
    setInputs2(s);
    e.name = n;
    e.exp  = ex;
    sbq.push_back(e);
    repeat (cyc) @(negedge clk);
    checkOutput(dut2Out());
  endtask

  initial begin
    // Power-on: press edge to power_state takes DB+1 cycles; hold gives one pulse
    addVec("pwr_latency_pre", P,     4,  1'b0, 2'b00, 2'b00, 2'b00, 16'd0);
    addVec("pwr_on",          P,     1,  1'b1, 2'b00, 2'b00, 2'b00, 16'd0);
    addVec("pwr_hold",        P,     5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd0);
    addVec("pwr_release",     8'h00, 6,  1'b1, 2'b00, 2'b00, 2'b00, 16'd0);
    // Manual drive sequence and mileage accumulation
    addVec("starting",        C|T,   1,  1'b1, 2'b00, 2'b01, 2'b00, 16'd0);
    addVec("moving",          T,     1,  1'b1, 2'b00, 2'b10, 2'b00, 16'd0);
    addVec("mileage_2",       T,     25, 1'b1, 2'b00, 2'b10, 2'b00, 16'd2);
    addVec("brake_stop",      T|B,   1,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    // Stall from standstill, then inputs ignored while off
    addVec("stall",           T,     1,  1'b0, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("off_ignores",     C|T,   3,  1'b0, 2'b00, 2'b00, 2'b00, 16'd2);
    // Reverse toggle without clutch while moving powers off
    addVec("pwr_on2",         P,     5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("pwr_rel2",        8'h00, 5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("starting2",       C|T,   1,  1'b1, 2'b00, 2'b01, 2'b00, 16'd2);
    addVec("moving2",         T,     1,  1'b1, 2'b00, 2'b10, 2'b00, 16'd2);
    addVec("reverse_fault",   T|V,   1,  1'b0, 2'b00, 2'b00, 2'b00, 16'd2);
    // Reverse toggle with clutch held: clutch rule applies, power stays on
    addVec("pwr_on3",         P|V,   5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("pwr_rel3",        V,     5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("starting3",       C|T|V, 1,  1'b1, 2'b00, 2'b01, 2'b00, 16'd2);
    addVec("moving3",         T|V,   1,  1'b1, 2'b00, 2'b10, 2'b00, 16'd2);
    addVec("reverse_clutch",  C|T,   1,  1'b1, 2'b00, 2'b01, 2'b00, 16'd2);
    // Mode button ignored in STARTING, steps 00->01->10->00 in NOT_STARTING
    addVec("mode_in_starting",MD|C|T,5,  1'b1, 2'b00, 2'b01, 2'b00, 16'd2);
    addVec("mode_st_release", C|T,   5,  1'b1, 2'b00, 2'b01, 2'b00, 16'd2);
    addVec("brake_to_ns",     C|B,   1,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("mode_01",         MD,    5,  1'b1, 2'b01, 2'b00, 2'b00, 16'd2);
    addVec("mode_01_release", 8'h00, 5,  1'b1, 2'b01, 2'b00, 2'b00, 16'd2);
    addVec("mode_10",         MD,    5,  1'b1, 2'b10, 2'b00, 2'b00, 16'd2);
    addVec("mode_10_release", 8'h00, 5,  1'b1, 2'b10, 2'b00, 2'b00, 16'd2);
    addVec("auto_holds_ns",   C|T,   3,  1'b1, 2'b10, 2'b00, 2'b00, 16'd2);
    addVec("mode_00",         MD,    5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("mode_00_release", 8'h00, 5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    // Turn indicators
    addVec("left",            L,     5,  1'b1, 2'b00, 2'b00, 2'b10, 16'd2);
    addVec("left_release",    8'h00, 5,  1'b1, 2'b00, 2'b00, 2'b10, 16'd2);
    addVec("right",           R,     5,  1'b1, 2'b00, 2'b00, 2'b01, 16'd2);
    addVec("right_release",   8'h00, 5,  1'b1, 2'b00, 2'b00, 2'b01, 16'd2);
    addVec("right_again",     R,     5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("right_again_rel", 8'h00, 5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("left2",           L,     5,  1'b1, 2'b00, 2'b00, 2'b10, 16'd2);
    addVec("left2_release",   8'h00, 5,  1'b1, 2'b00, 2'b00, 2'b10, 16'd2);
    addVec("both_turns",      L|R,   5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);
    addVec("both_release",    8'h00, 5,  1'b1, 2'b00, 2'b00, 2'b00, 16'd2);

    rst = 1'b1;
    setInputs(8'h00);
    setInputs2(8'h00);
    repeat (3) @(negedge clk);
    begin
      sb_t e;
      e.name = "reset_state";
      e.exp  = pk(1'b0, 2'b00, 2'b00, 2'b00, 16'd0);
      sbq.push_back(e);
      checkOutput(dutOut());
    end
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(dutOut());
    end

    // Prescaler kept its partial count (8) across power-offs, so the next
    // mileage tick arrives early; then reset while moving clears everything.
    step("start4",       C|T, 1, 1'b1, 2'b00, 2'b01, 2'b00, 16'd2);
    step("moving4",      T,   1, 1'b1, 2'b00, 2'b10, 2'b00, 16'd2);
    step("left_moving",  L|T, 5, 1'b1, 2'b00, 2'b10, 2'b10, 16'd3);
    rst = 1'b1;
    step("rst_moving",   T,   1, 1'b0, 2'b00, 2'b00, 2'b00, 16'd0);
    rst = 1'b0;

    // Power press arriving in the same cycle as a stall condition
    step("pwr_on5",      P,     5, 1'b1, 2'b00, 2'b00, 2'b00, 16'd0);
    step("pwr_rel5",     8'h00, 5, 1'b1, 2'b00, 2'b00, 2'b00, 16'd0);
    step("pwr_press_pre",P,     4, 1'b1, 2'b00, 2'b00, 2'b00, 16'd0);
    step("pwr_vs_stall", P|T,   1, 1'b0, 2'b00, 2'b00, 2'b00, 16'd0);
    step("pwr_vs_stall_hold", P|T, 4, 1'b0, 2'b00, 2'b00, 2'b00, 16'd0);
    setInputs(8'h00);

    // Odometer wrap on the one-cycle-tick instance
    step2("w_pwr_on",  P,     5, pk(1'b1, 2'b00, 2'b00, 2'b00, 16'd0));
    step2("w_pwr_rel", 8'h00, 5, pk(1'b1, 2'b00, 2'b00, 2'b00, 16'd0));
    step2("w_start",   C|T,   1, pk(1'b1, 2'b00, 2'b01, 2'b00, 16'd0));
    step2("w_moving",  T,     1, pk(1'b1, 2'b00, 2'b10, 2'b00, 16'd0));
    step2("w_ffff",    T, 65536, pk(1'b1, 2'b00, 2'b10, 2'b00, 16'hFFFF));
    step2("w_wrap",    T,     1, pk(1'b1, 2'b00, 2'b10, 2'b00, 16'h0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
